// File: rtl/sha256_core_arbiter.sv
// Round-robin arbiter that shares one sha256_block core between NREQ hash lanes.
// Optional watchdog enabled by `define SHA_ARB_TIMEOUT_EN; the core's reset_n is ~reset.
module sha256_core_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 128
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ-1:0][7:0][31:0]     req_h_init,
    input  logic [NREQ-1:0][511:0]         req_block,
    output logic                           core_start,
    output logic [7:0][31:0]               core_h_init,
    output logic [511:0]                   core_block,
    input  logic [7:0][31:0]               core_hash,
    input  logic                           core_done,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [$clog2(NREQ)-1:0]        rsp_id,
    output logic [7:0][31:0]               rsp_hash,
    output logic                           rsp_err
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_next;
    logic [IW-1:0] last, pick, cur_id;
    logic          pick_valid;
    logic          timeout_hit;
    int            cand;

    if (NREQ < 2 || NREQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("sha256_core_arbiter: parameter out of range");
    end

    // Search starts one past the last winner so every waiting lane is served in turn.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pick       = '0;
        pick_valid = 1'b0;
        cand       = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(last) + i) % NREQ;
            if (!pick_valid && req_valid[cand]) begin
                pick_valid = 1'b1;
                pick       = IW'(cand);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && pick_valid) req_ready[pick] = 1'b1;
    end

    assign core_start = (state == ISSUE);
    assign rsp_valid  = (state == RESP);
    assign rsp_id     = cur_id;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (pick_valid) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT:  if (core_done || timeout_hit) state_next = RESP;
            RESP:  if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        // NOTE: the wide data registers are reset because downstream logic observes their reset value of 0.
        if (reset) begin
            last        <= IW'(NREQ - 1);
            cur_id      <= '0;
            core_h_init <= '0;
            core_block  <= '0;
            rsp_hash    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        core_h_init <= req_h_init[pick];
                        core_block  <= req_block[pick];
                        cur_id      <= pick;
                        last        <= pick;
                    end
                end
                WAIT: begin
                    if (core_done)        rsp_hash <= core_hash;
                    else if (timeout_hit) rsp_hash <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef SHA_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset)               wait_cnt <= '0;
        else if (state == ISSUE) wait_cnt <= '0;
        else if (state == WAIT)  wait_cnt <= wait_cnt + CW'(1);
    end

    // Fires in the last allowed WAIT cycle; a done in that same cycle still wins.
    assign timeout_hit = (state == WAIT) && !core_done && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset)                              rsp_err <= 1'b0;
        else if (state == WAIT && core_done)    rsp_err <= 1'b0;
        else if (timeout_hit)                   rsp_err <= 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Bench for sha256_core_arbiter: behavioural SHA-256 core stub, round-robin reference model,
// directed and randomized requests; the timeout scenario runs when SHA_ARB_TIMEOUT_EN is defined.
module tb_sha256_core_arbiter;

    localparam int NREQ = 4;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [7:0][31:0] IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };
    localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'h0, 32'h00000018};

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NREQ-1:0]            req_valid, req_ready;
    logic [NREQ-1:0][7:0][31:0] req_h_init;
    logic [NREQ-1:0][511:0]     req_block;
    logic                       core_start, core_done;
    logic [7:0][31:0]           core_h_init, core_hash;
    logic [511:0]               core_block;
    logic                       rsp_valid, rsp_ready, rsp_err;
    logic [1:0]                 rsp_id;
    logic [7:0][31:0]           rsp_hash;

    int   cyc = 0;
    int   checks = 0, failures = 0;
    int   model_last;
    int   stub_cnt;
    logic spur = 1'b0, stub_hang = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha256_core_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(128)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_h_init(req_h_init), .req_block(req_block),
        .core_start(core_start), .core_h_init(core_h_init), .core_block(core_block),
        .core_hash(core_hash), .core_done(core_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_hash(rsp_hash), .rsp_err(rsp_err)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Plain FIPS 180-4 compression of one block.
    function automatic logic [7:0][31:0] sha256_ref(input logic [7:0][31:0] hi, input logic [511:0] blk);
        logic [31:0]      w [64];
        logic [31:0]      v [8];
        logic [31:0]      t1, t2;
        logic [7:0][31:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3))
                 + w[t-7]  + (ror(w[t-2], 17) ^ ror(w[t-2], 19)  ^ (w[t-2] >> 10));
        for (int i = 0; i < 8; i++) v[i] = hi[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[i] = hi[i] + v[i];
        return r;
    endfunction

    // Core stub: samples start, raises done 65 cycles later, reads its inputs live at that point.
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (reset) begin
            stub_cnt  <= 0;
            core_hash <= '0;
        end else if (spur) begin
            core_done <= 1'b1;
            core_hash <= {8{32'($urandom)}};
        end else if (core_start) begin
            stub_cnt <= 65;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1 && !stub_hang) begin
                core_done <= 1'b1;
                core_hash <= sha256_ref(core_h_init, core_block);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=no_finish required=finish");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick();
        for (int i = 1; i <= NREQ; i++)
            if (req_valid[(model_last + i) % NREQ]) return (model_last + i) % NREQ;
        return -1;
    endfunction

    // Returns at the accept edge A with the granted id and the expected hash of its data.
    task automatic wait_grant(output int id, output int acc, output logic [255:0] exp, output logic [511:0] blk);
        int              pick;
        bit              got = 1'b0;
        logic [NREQ-1:0] exp_rdy;
        for (int n = 0; n < 300; n++) begin
            #1;
            if (req_ready != '0) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("grant_seen", 512'(got), 512'(1));
        pick    = model_pick();
        exp_rdy = (pick >= 0) ? NREQ'(1 << pick) : '0;
        check("grant_round_robin", 512'(req_ready), 512'(exp_rdy));
        if (pick >= 0) model_last = pick;
        id = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) id = i;
        exp = sha256_ref(req_h_init[id], req_block[id]);
        blk = req_block[id];
        acc = cyc + 1;
        @(posedge clk);
    endtask

    task automatic wait_rsp(input int exp_id, input logic [255:0] exp_hash, input int acc, input logic [511:0] orig);
        int starts  = 0;
        bit changed = 1'b0;
        bit got     = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (core_start) starts++;
            if (core_block !== orig) changed = 1'b1;
            if (rsp_valid) begin got = 1'b1; break; end
        end
        check("rsp_seen", 512'(got), 512'(1));
        check("start_pulse_count", 512'(starts), 512'(1));
        check("core_block_stable", 512'(changed), 512'(0));
        check("rsp_latency", 512'(cyc), 512'(acc + 67));
        check("rsp_id", 512'(rsp_id), 512'(exp_id));
        check("rsp_hash", 512'(rsp_hash), 512'(exp_hash));
        check("rsp_err", 512'(rsp_err), 512'(0));
    endtask

    task automatic finish_rsp();
        check("no_grant_in_resp", 512'(req_ready), 512'(0));
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rsp_released", 512'(rsp_valid), 512'(0));
    endtask

    initial begin
        int               id, acc;
        logic [255:0]     exp;
        logic [511:0]     blk;
        logic [7:0][31:0] held;
        bit               bad;

        reset = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        req_h_init = '0; req_block = '0;
        model_last = NREQ - 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 512'(req_ready), 512'(0));
        check("reset_core_start", 512'(core_start), 512'(0));
        check("reset_rsp_valid", 512'(rsp_valid), 512'(0));
        check("reset_rsp_err", 512'(rsp_err), 512'(0));
        check("reset_rsp_id", 512'(rsp_id), 512'(0));
        check("reset_rsp_hash", 512'(rsp_hash), 512'(0));
        check("reset_core_block", core_block, 512'(0));
        check("reset_core_h_init", 512'(core_h_init), 512'(0));

        // Fairness: all lanes busy from reset
        for (int r = 0; r < NREQ; r++) begin
            for (int w = 0; w < 8; w++) req_h_init[r][w] = $urandom;
            for (int w = 0; w < 16; w++) req_block[r][511 - 32*w -: 32] = $urandom;
        end
        reset = 1'b0;
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            wait_grant(id, acc, exp, blk);
            check("fair_order", 512'(id), 512'(k % NREQ));
            wait_rsp(id, exp, acc, blk);
            finish_rsp();
        end

        // Single "abc" request on requester 2
        req_valid = 4'b0100;
        req_h_init[2] = IV;
        req_block[2]  = ABC_BLOCK;
        wait_grant(id, acc, exp, blk);
        check("abc_grant_id", 512'(id), 512'(2));
        #1 req_valid = '0;
        wait_rsp(2, exp, acc, blk);
        check("abc_word0", 512'(rsp_hash[0]), 512'(32'hba7816bf));
        check("abc_word7", 512'(rsp_hash[7]), 512'(32'hf20015ad));
        finish_rsp();

        // Stray core_done while idle
        spur = 1'b1;
        @(posedge clk);
        #1 spur = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("stray_done_rsp_valid", 512'(rsp_valid), 512'(0));
        check("stray_done_core_start", 512'(core_start), 512'(0));
        check("stray_done_rsp_hash", 512'(rsp_hash), 512'(exp));

        // Input stability: requester data changes right after accept
        req_valid = '1;
        wait_grant(id, acc, exp, blk);
        #1 req_block[id] = ~req_block[id];
        wait_rsp(id, exp, acc, blk);
        finish_rsp();

        // Backpressure with other requests pending
        rsp_ready = 1'b0;
        wait_grant(id, acc, exp, blk);
        wait_rsp(id, exp, acc, blk);
        held = rsp_hash;
        bad  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_hash !== held || req_ready !== '0) bad = 1'b1;
        end
        check("backpressure_hold", 512'(bad), 512'(0));
        finish_rsp();
        wait_grant(id, acc, exp, blk);
        wait_rsp(id, exp, acc, blk);
        finish_rsp();

        // Reset in the middle of WAIT
        req_valid = 4'b1000;
        wait_grant(id, acc, exp, blk);
        check("prereset_grant", 512'(id), 512'(3));
        #1 req_valid = '0;
        while (cyc < acc + 29) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midwait_reset_rsp_valid", 512'(rsp_valid), 512'(0));
        check("midwait_reset_core_start", 512'(core_start), 512'(0));
        reset = 1'b0;
        model_last = NREQ - 1;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad = 1'b1;
        end
        check("dropped_request_no_rsp", 512'(bad), 512'(0));
        req_valid = '1;
        wait_grant(id, acc, exp, blk);
        check("post_reset_grant", 512'(id), 512'(0));
        wait_rsp(id, exp, acc, blk);
        finish_rsp();

        // Randomized requests against the model
        for (int it = 0; it < 12; it++) begin
            for (int r = 0; r < NREQ; r++) begin
                for (int w = 0; w < 8; w++) req_h_init[r][w] = $urandom;
                for (int w = 0; w < 16; w++) req_block[r][511 - 32*w -: 32] = $urandom;
            end
            req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            rsp_ready = 1'($urandom_range(0, 1));
            wait_grant(id, acc, exp, blk);
            #1 if ($urandom_range(0, 1) == 1) req_valid[id] = 1'b0;
            wait_rsp(id, exp, acc, blk);
            finish_rsp();
        end
        req_valid = '0;

`ifdef SHA_ARB_TIMEOUT_EN
        // Watchdog: core never finishes
        stub_hang = 1'b1;
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        wait_grant(id, acc, exp, blk);
        #1 req_valid = '0;
        bad = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (rsp_valid) begin bad = 1'b0; break; end
        end
        check("timeout_rsp_seen", 512'(bad), 512'(0));
        check("timeout_latency", 512'(cyc), 512'(acc + 129));
        check("timeout_rsp_err", 512'(rsp_err), 512'(1));
        check("timeout_rsp_hash", 512'(rsp_hash), 512'(0));
        check("timeout_rsp_id", 512'(rsp_id), 512'(id));
        spur = 1'b1;
        @(posedge clk);
        #1 spur = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("late_done_rsp_valid", 512'(rsp_valid), 512'(1));
        check("late_done_rsp_hash", 512'(rsp_hash), 512'(0));
        check("late_done_rsp_err", 512'(rsp_err), 512'(1));
        finish_rsp();
        stub_hang = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha256_core_arbiter.md
# sha256_core_arbiter

Round-robin scheduler that shares one `sha256_block` compression core between `NREQ` requesters, such as per-nonce hash lanes in the bitcoin miner.
- Accepts one request at a time: a 512-bit message block plus an 8-word initial hash.
- Captures the request, pulses the core's `start` and holds the core inputs stable while it computes.
- Returns the core's 8-word hash tagged with the requester index.
- Sits between the hash-lane controllers and the single `sha256_block` instance.

## Interface
- `NREQ`, 4, number of requesters; legal range 2..16.
- `TIMEOUT_CYCLES`, 128, watchdog limit in cycles; used only with `SHA_ARB_TIMEOUT_EN`.
- `clk`  in  1  the only clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  [NREQ]  request pending, one bit per requester.
- `req_ready`  out  [NREQ]  one-hot grant/accept; the request transfers on `req_valid[k] & req_ready[k]`.
- `req_h_init`  in  [NREQ][8] x 32  initial hash words per requester.
- `req_block`  in  [NREQ] x 512  message block per requester; bits 511:480 are word 0.
- `core_start`  out  1  single-cycle start pulse to the core.
- `core_h_init`  out  [8] x 32  registered copy of the accepted h_init.
- `core_block`  out  512  registered copy of the accepted block.
- `core_hash`  in  [8] x 32  hash from the core; valid while `core_done` is high.
- `core_done`  in  1  one-cycle completion pulse from the core.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  $clog2(NREQ)  index of the requester that owns the response.
- `rsp_hash`  out  [8] x 32  registered result.
- `rsp_err`  out  1  response is a timeout abort; tied 0 without `SHA_ARB_TIMEOUT_EN`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Round-robin pick: the first requester with `req_valid` set, searching from `last+1` modulo NREQ.
  - `req_ready` is combinational, one-hot to the pick, and nonzero only in IDLE.
  - On handshake: register h_init, block and id; set `last` to the id; go to ISSUE.
  - With no valid requests: stay in IDLE and leave `last` unchanged.
- **ISSUE**: drive `core_start` = 1 for exactly this cycle, then go to WAIT.
- **WAIT**
  - `core_block` and `core_h_init` stay constant; the core reads the block live throughout its rounds.
  - When `core_done` = 1: register `core_hash` into `rsp_hash`, set `rsp_err` = 0, go to RESP.
- **RESP**
  - `rsp_valid` = 1; `rsp_id`, `rsp_hash` and `rsp_err` are held stable until `rsp_ready`.
  - On `rsp_valid & rsp_ready`: go to IDLE. No new grant is issued in this same cycle.
- Requesters must hold `req_valid` and their data until granted. Dropping `req_valid` without a grant is allowed and simply removes the request from arbitration.
- `core_done` outside WAIT is ignored; no state change occurs.
- Integration: the core's `reset_n` is driven from `~reset`.

## Timing
- Reset values:
  - state IDLE, `last` = NREQ-1, so requester 0 wins first.
  - `req_ready` = 0, `core_start` = 0, `rsp_valid` = 0, `rsp_err` = 0, `rsp_id` = 0.
  - `rsp_hash`, `core_block` and `core_h_init` = 0.
- Accept edge A: `core_start` is high during cycle A+1.
- The core raises `done` 65 cycles after it samples start. `rsp_valid` rises at the edge after the cycle in which `core_done` is high, i.e. A+67 nominally.
- Back-to-back throughput is at most one request per (core latency + 4) cycles.
- Reset asserted in any state returns to IDLE on the next edge. Any in-flight request is dropped with no response.
- `rsp_ready` held low: the block stays in RESP indefinitely, and `req_ready` stays 0 for all requesters.

## Configuration
- `SHA_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` without `core_done`: go to RESP with `rsp_hash` = 0 and `rsp_err` = 1.
  - A late `core_done` is then ignored by the rule above.
- `SHA_ARB_TIMEOUT_EN` undefined: no counter is built, WAIT waits forever, and `rsp_err` is the constant 0.

## Test plan
- **Single request**:
  - Stimulus: requester 2 valid with the standard SHA-256 IV and the padded "abc" block; `rsp_ready` = 1.
  - Response: `rsp_id` = 2, `rsp_hash[0]` = 32'hba7816bf, `rsp_hash[7]` = 32'hf20015ad.
  - `core_start` is high for exactly 1 cycle; `rsp_valid` rises at A+67.
- **Fairness**: all 4 requesters valid continuously → grant order 0,1,2,3,0,1.
  - No requester is granted twice while another is waiting.
- **Input stability**: change `req_block[id]` on the cycle after accept.
  - `core_block` stays unchanged through WAIT, and the hash still matches the original block.
- **Backpressure**:
  - Hold `rsp_ready` = 0 for 20 cycles with other requests pending.
  - `rsp_valid` and `rsp_hash` stay stable, `req_ready` = 0 throughout, and the next grant follows the response handshake.
- **Reset mid-WAIT**: assert `reset` during cycle A+30.
  - Next edge: IDLE, `rsp_valid` = 0, no response ever produced for that request; the next grant goes to requester 0.
- **Timeout** (macro on, core stubbed to never finish, `TIMEOUT_CYCLES` = 128):
  - `rsp_err` = 1 and `rsp_hash` = 0 after 128 WAIT cycles; a later `core_done` pulse is ignored.
